// File: rtl/zacore_imem_responder.sv
// Instruction-memory responder for the fetch req/ack interface, backed by a preloadable word RAM.
// Optional random extra latency: define ZACORE_IMEM_RANDOM_LATENCY_EN.
module zacore_imem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_req,
  output logic        o_fetch_ack,
  input  logic [31:0] i_fetch_addr,
  output logic [31:0] o_inst_read,
  input  logic        i_load_we,
  input  logic [31:0] i_load_addr,
  input  logic [31:0] i_load_data,
  output logic        o_busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q;
  logic            in_range_q;
  logic [31:0]     inst_q;
  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   fetch_idx, load_idx, rd_idx;
  logic            fetch_in_range, load_in_range, rd_in_range;
  logic            capture, enter_ack;
  logic [4:0]      extra_lat, total_lat;
  logic            unused_addr_bits;

  // Word index plus range flag: address is in range when every bit above the index is zero.
  assign fetch_idx        = i_fetch_addr[AW+1:2];
  assign fetch_in_range   = ~|i_fetch_addr[31:AW+2];
  assign load_idx         = i_load_addr[AW+1:2];
  assign load_in_range    = ~|i_load_addr[31:AW+2];
  assign unused_addr_bits = ^{i_fetch_addr[1:0], i_load_addr[1:0]};

`ifdef ZACORE_IMEM_RANDOM_LATENCY_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;

  // Fibonacci LFSR, taps 8,6,5,4.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge i_clk) begin
    if (i_rst) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_fb};
  end

  assign extra_lat = {3'b000, lfsr_q[1:0]};
`else
  assign extra_lat = 5'd0;
`endif

  assign total_lat = 5'(LATENCY) + extra_lat;

  // A direct IDLE->ACK transition reads with the live address; otherwise the captured one.
  assign rd_idx      = (state_q == ST_IDLE) ? fetch_idx      : idx_q;
  assign rd_in_range = (state_q == ST_IDLE) ? fetch_in_range : in_range_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    enter_ack = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_fetch_req) begin
          capture = 1'b1;
          if (total_lat == 5'd1) begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end else begin
            cnt_d   = total_lat - 5'd2;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!i_fetch_req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 5'd0) begin
          state_d   = ST_ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 5'd0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      inst_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        idx_q      <= fetch_idx;
        in_range_q <= fetch_in_range;
      end
      // Reads the pre-edge array word, so a same-edge load returns the old data.
      if (enter_ack) inst_q <= rd_in_range ? mem[rd_idx] : 32'h0;
    end
  end

  // NOTE: the array is deliberately not reset; the load port stays live even while i_rst is high.
  always_ff @(posedge i_clk) begin
    if (i_load_we && load_in_range) mem[load_idx] <= i_load_data;
  end

  assign o_fetch_ack = (state_q == ST_ACK);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_inst_read = inst_q;

endmodule

// File: tb/tb_zacore_imem_responder.sv
// Scoreboard bench for zacore_imem_responder: one instance at LATENCY=1 and one at LATENCY=4.
// With ZACORE_IMEM_RANDOM_LATENCY_EN defined it runs 100 random-latency fetches instead of the directed timing tests.
module tb_zacore_imem_responder;

  localparam int LAT4 = 4;
`ifdef ZACORE_IMEM_RANDOM_LATENCY_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        lwe;
  logic [31:0] laddr, ldata;

  logic        req1, ack1, busy1;
  logic [31:0] addr1, inst1;
  logic        req4, ack4, busy4;
  logic [31:0] addr4, inst4;

  logic [31:0] q1[$];
  logic [31:0] q4[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  zacore_imem_responder #(.DEPTH(1024), .LATENCY(1), .LFSR_SEED(8'hA5)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_fetch_req(req1), .o_fetch_ack(ack1),
    .i_fetch_addr(addr1), .o_inst_read(inst1), .i_load_we(lwe),
    .i_load_addr(laddr), .i_load_data(ldata), .o_busy(busy1)
  );

  zacore_imem_responder #(.DEPTH(1024), .LATENCY(LAT4), .LFSR_SEED(8'hA5)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_fetch_req(req4), .o_fetch_ack(ack4),
    .i_fetch_addr(addr4), .o_inst_read(inst4), .i_load_we(lwe),
    .i_load_addr(laddr), .i_load_data(ldata), .o_busy(busy4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitors: pop the expected word whenever a DUT acknowledges.
  always @(negedge clk) begin
    if (ack1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut1_unexpected_ack actual=%h required=no_ack", inst1);
      end else check("dut1_data", inst1, q1.pop_front());
    end
    if (ack4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut4_unexpected_ack actual=%h required=no_ack", inst4);
      end else check("dut4_data", inst4, q4.pop_front());
    end
  end

  // step() lands just after a rising edge (start of a cycle); sample() waits for mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    lwe = 1'b1; laddr = a; ldata = d;
    step();
    lwe = 1'b0;
  endtask

  task automatic wait_ack4(input int lo, input int hi);
    int  n   = 0;
    bit  got = 1'b0;
    while (!got && n < 30) begin
      step();
      n++;
      sample();
      if (ack4 === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || n < lo || n > hi) begin
      failures++;
      $display("FAIL dut4_latency actual=%0d required=%0d..%0d", n, lo, hi);
    end
  endtask

  // Issue at the start of a cycle, wait for ack, then drop req in the following IDLE cycle.
  task automatic fetch4(input logic [31:0] a, input logic [31:0] d);
    req4 = 1'b1; addr4 = a;
    q4.push_back(d);
    wait_ack4(LAT4, LAT4 + EXTRA);
    step();
    req4 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] words [4];
    words[0] = 32'h0050_0093; words[1] = 32'h00a0_0113;
    words[2] = 32'h2222_2222; words[3] = 32'hDEAD_BEEF;

    rst = 1'b1; lwe = 1'b0; laddr = '0; ldata = '0;
    req1 = 1'b0; addr1 = '0; req4 = 1'b0; addr4 = '0;

    step();
    load(32'h0, words[0]);            // written while reset is still asserted
    sample();
    check("rst_ack1", {31'b0, ack1}, 32'h0);
    check("rst_busy1", {31'b0, busy1}, 32'h0);
    check("rst_inst1", inst1, 32'h0);
    check("rst_ack4", {31'b0, ack4}, 32'h0);
    check("rst_busy4", {31'b0, busy4}, 32'h0);
    check("rst_inst4", inst4, 32'h0);
    step();
    rst = 1'b0;
    load(32'h4, words[1]);
    load(32'h8, words[2]);
    load(32'hC, words[3]);
    load(32'h1000, 32'hFFFF_FFFF);    // out of range: must be dropped

`ifndef ZACORE_IMEM_RANDOM_LATENCY_EN
    // LATENCY=1: back-to-back held request.
    req1 = 1'b1; addr1 = 32'h0; q1.push_back(words[0]);
    sample();
    check("l1_c0_ack", {31'b0, ack1}, 32'h0);
    step(); addr1 = 32'h4; q1.push_back(words[1]);
    sample();
    check("l1_c1_ack", {31'b0, ack1}, 32'h1);
    check("l1_c1_busy", {31'b0, busy1}, 32'h1);
    step(); sample();
    check("l1_c2_ack", {31'b0, ack1}, 32'h0);
    check("l1_c2_busy", {31'b0, busy1}, 32'h0);
    step(); req1 = 1'b0; sample();
    check("l1_c3_ack", {31'b0, ack1}, 32'h1);
    step(); sample();
    check("l1_c4_ack", {31'b0, ack1}, 32'h0);
    step();

    // LATENCY=4: busy window, single ack, address change after capture ignored.
    req4 = 1'b1; addr4 = 32'h8; q4.push_back(words[2]);
    sample();
    check("l4_c0_busy", {31'b0, busy4}, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 2) addr4 = 32'h0;
      sample();
      check("l4_busy", {31'b0, busy4}, 32'h1);
      check("l4_ack", {31'b0, ack4}, (c == 4) ? 32'h1 : 32'h0);
    end
    step(); req4 = 1'b0; sample();
    check("l4_c5_busy", {31'b0, busy4}, 32'h0);
    step();

    // Abort in WAIT: no ack, output holds its last value.
    req4 = 1'b1; addr4 = 32'h4;
    sample(); step(); sample(); step();
    req4 = 1'b0; sample();
    check("abort_c2_busy", {31'b0, busy4}, 32'h1);
    step(); sample();
    check("abort_c3_busy", {31'b0, busy4}, 32'h0);
    check("abort_c3_ack", {31'b0, ack4}, 32'h0);
    check("abort_c3_inst", inst4, words[2]);
    for (int i = 0; i < 3; i++) begin
      step(); sample();
      check("abort_no_ack", {31'b0, ack4}, 32'h0);
    end
    step();
    fetch4(32'h0, words[0]);          // also proves the 0x1000 load did not alias word 0

    // Out of range fetch and ignored low address bits.
    fetch4(32'h0000_1000, 32'h0);
    fetch4(32'h0000_000B, words[2]);

    // Load on the edge that enters ACK: old data returned, new data on refetch.
    req4 = 1'b1; addr4 = 32'hC; q4.push_back(32'hDEAD_BEEF);
    step(); step(); step();
    lwe = 1'b1; laddr = 32'hC; ldata = 32'h1234_5678;
    step();
    lwe = 1'b0; sample();
    check("rbw_ack", {31'b0, ack4}, 32'h1);
    step(); req4 = 1'b0;
    fetch4(32'hC, 32'h1234_5678);
    words[3] = 32'h1234_5678;
`else
    for (int i = 0; i < 100; i++) fetch4(32'(i % 4) << 2, words[i % 4]);
`endif

    // Reset during WAIT drops the transaction; contents survive.
    req4 = 1'b1; addr4 = 32'hC;
    step(); step();
    rst = 1'b1; sample();
    step();
    rst = 1'b0; req4 = 1'b0; sample();
    check("rst_wait_ack", {31'b0, ack4}, 32'h0);
    check("rst_wait_busy", {31'b0, busy4}, 32'h0);
    check("rst_wait_inst", inst4, 32'h0);
    step();
    fetch4(32'hC, words[3]);
    fetch4(32'h0, words[0]);

    repeat (4) step();
    check("q1_drained", q1.size(), 32'h0);
    check("q4_drained", q4.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zacore_imem_responder.md
Name: zacore_imem_responder

Overview:
Instruction-memory responder that sits on the memory side of the core's fetch request/acknowledge interface.
- Accepts a fetch request and address, waits a configurable latency, then returns the instruction word with a one-cycle acknowledge.
- Backed by a word-addressed RAM, with a side load port used by the bench and boot loader to preload program images.
- Used for simulation and FPGA bring-up of the fetch stage.

Parameters:
DEPTH, 1024, number of 32-bit words in the array; power of two, ≥ 2.
LATENCY, 1, cycles from request capture to ack; legal range 1–15.
LFSR_SEED, 8'hA5, nonzero seed for the random-latency LFSR (used only when the optional feature is on).

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_fetch_req  input  1  fetch request from fetch stage; held until ack or abort
o_fetch_ack  output  1  single-cycle acknowledge; o_inst_read valid in the same cycle
i_fetch_addr  input  32  byte address of the instruction
o_inst_read  output  32  instruction word returned
i_load_we  input  1  load-port write enable
i_load_addr  input  32  load-port byte address
i_load_data  input  32  load-port write data
o_busy  output  1  high while a request is outstanding (WAIT or ACK)

Behaviour:
- Reset state (i_rst sampled high at a clock edge):
  - State IDLE; o_fetch_ack=0, o_inst_read=32'h0, o_busy=0, latency counter=0.
  - LFSR reloads LFSR_SEED.
  - Array contents are NOT cleared.
  - Reset mid-WAIT or mid-ACK drops the transaction; no ack is issued.
- States: IDLE, WAIT, ACK.
- IDLE:
  - On an edge with i_fetch_req=1, latch word index = i_fetch_addr[log2(DEPTH)+1:2] plus an in-range flag (i_fetch_addr[31:2] < DEPTH).
  - Go to ACK if LATENCY=1; otherwise load counter with LATENCY-2 and go to WAIT.
- WAIT:
  - If i_fetch_req=0 at an edge: abort and return to IDLE; no ack, o_inst_read unchanged.
  - Else if counter=0: go to ACK. Else decrement the counter.
  - Changes on i_fetch_addr after capture are ignored.
- Transition into ACK: o_inst_read registered from the array at that edge, or 32'h0 if out of range.
- ACK:
  - o_fetch_ack=1 for exactly one cycle; always go to IDLE at the next edge, regardless of i_fetch_req.
  - If req is still high in the following IDLE cycle, it is a new request, captured at the next edge.
- Latency: req first high in cycle 0 → ack in cycle LATENCY. Maximum throughput is one word per LATENCY+1 cycles.
- o_inst_read holds its last value outside ACK; it is meaningful only while ack=1.
- Address handling:
  - i_fetch_addr[1:0] ignored (word aligned).
  - Out-of-range fetch returns 32'h0 with a normal ack and normal timing.
- Load port:
  - Write at the edge when i_load_we=1, to word i_load_addr[log2(DEPTH)+1:2].
  - Out-of-range load writes are dropped.
  - The load port works in every state, including during reset.
- Simultaneous load and fetch read of the same word on the same edge: read-before-write, so the fetch returns the OLD data.
- o_busy = (state != IDLE).

Optional Feature:
ZACORE_IMEM_RANDOM_LATENCY_EN
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) advances on every edge not in reset.
  - At capture, LFSR[1:0] (0–3) extra wait cycles are added to LATENCY for that transaction.
  - Abort, reset and data rules are unchanged.
  - Used to stress fetch-stage stall handling.
- Not defined: no LFSR logic; latency is exactly LATENCY.

Test Plan:
- LATENCY=1, load word 0=32'h00500093, word 1=32'h00a00113; req at addr 0x0 held → ack in cycle 1 with 0x00500093. Req at 0x4 captured in cycle 2 → ack in cycle 3 with 0x00a00113.
- LATENCY=4, req at 0x8 held → o_busy=1 in cycles 1–4, ack only in cycle 4. i_fetch_addr changed to 0x0 in cycle 2 → still returns word 2.
- LATENCY=4, req drops in cycle 2 → no ack, back to IDLE in cycle 3, o_inst_read unchanged. New req to 0x0 then completes normally.
- DEPTH=1024, req at 0x0000_1000 → ack after LATENCY with 32'h0. Load write to 0x1000 → no array word modified.
- Load 0x1234_5678 to word 3 on the same edge the fetch of word 3 enters ACK (old 0xDEAD_BEEF) → returns 0xDEADBEEF; refetch returns 0x12345678.
- Assert i_rst during WAIT → next cycle ack=0, o_busy=0, o_inst_read=0; loaded contents survive and a refetch returns them. With ZACORE_IMEM_RANDOM_LATENCY_EN: 100 fetches, each ack between LATENCY and LATENCY+3 cycles, data always correct.
